// File: rtl/mem_stage.sv
// Memory stage: performs the data-memory access over a req/ack handshake,
// stalls upstream while an access is outstanding, and feeds the M/W register.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] ALU_Out,
  input  logic [15:0] WrData,
  input  logic        MemWrt_2ff,
  input  logic        MemRead_2ff,
  input  logic        RegWrt_in,
  input  logic [2:0]  WrReg_in,
  input  logic [15:0] PC_2ff,
  input  logic        Halt_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        Stall,
  output logic        valid_3ff,
  output logic [15:0] WbData_3ff,
  output logic [2:0]  WrReg_3ff,
  output logic        RegWrt_3ff,
  output logic [15:0] PC_3ff,
  output logic        Halt_3ff,
  output logic        Err_3ff
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        halted_reg, halted_next;
  logic        req_reg, req_next;
  logic        wr_reg, wr_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;

  logic        mw_valid_reg, mw_valid_next;
  logic [15:0] mw_data_reg, mw_data_next;
  logic [2:0]  mw_wrreg_reg, mw_wrreg_next;
  logic        mw_regwrt_reg, mw_regwrt_next;
  logic [15:0] mw_pc_reg, mw_pc_next;
  logic        mw_halt_reg, mw_halt_next;
  logic        mw_err_reg, mw_err_next;

  logic memop;
  logic misaligned;
  logic stall_comb;

  assign memop      = valid_in & (MemRead_2ff | MemWrt_2ff);
  assign misaligned = memop & ALU_Out[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      halted_reg    <= 1'b0;
      req_reg       <= 1'b0;
      wr_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      mw_valid_reg  <= 1'b0;
      mw_data_reg   <= '0;
      mw_wrreg_reg  <= '0;
      mw_regwrt_reg <= 1'b0;
      mw_pc_reg     <= '0;
      mw_halt_reg   <= 1'b0;
      mw_err_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      halted_reg    <= halted_next;
      req_reg       <= req_next;
      wr_reg        <= wr_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      mw_valid_reg  <= mw_valid_next;
      mw_data_reg   <= mw_data_next;
      mw_wrreg_reg  <= mw_wrreg_next;
      mw_regwrt_reg <= mw_regwrt_next;
      mw_pc_reg     <= mw_pc_next;
      mw_halt_reg   <= mw_halt_next;
      mw_err_reg    <= mw_err_next;
    end
  end

  // The M/W register takes a bubble every cycle unless an instruction completes.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    halted_next    = halted_reg;
    req_next       = req_reg;
    wr_next        = wr_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    mw_valid_next  = 1'b0;
    mw_data_next   = '0;
    mw_wrreg_next  = '0;
    mw_regwrt_next = 1'b0;
    mw_pc_next     = '0;
    mw_halt_next   = 1'b0;
    mw_err_next    = 1'b0;
    stall_comb     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!halted_reg) begin
          if (memop && !misaligned) begin
            stall_comb = 1'b1;
            state_next = BUSY;
            cnt_next   = '0;
            req_next   = 1'b1;
            wr_next    = MemWrt_2ff;
            addr_next  = ALU_Out;
            wdata_next = WrData;
          end else if (valid_in) begin
            mw_valid_next  = 1'b1;
            mw_data_next   = ALU_Out;
            mw_wrreg_next  = WrReg_in;
            mw_regwrt_next = RegWrt_in & ~misaligned;
            mw_pc_next     = PC_2ff;
            mw_halt_next   = Halt_in;
            mw_err_next    = misaligned;
            if (Halt_in) begin
              halted_next = 1'b1;
            end
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          // An ack in the final permitted cycle still completes normally.
          state_next     = IDLE;
          req_next       = 1'b0;
          mw_valid_next  = 1'b1;
          mw_data_next   = wr_reg ? ALU_Out : mem_rdata;
          mw_wrreg_next  = WrReg_in;
          mw_regwrt_next = RegWrt_in;
          mw_pc_next     = PC_2ff;
          mw_halt_next   = Halt_in;
          if (Halt_in) begin
            halted_next = 1'b1;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next    = IDLE;
          req_next      = 1'b0;
          mw_valid_next = 1'b1;
          mw_data_next  = ALU_Out;
          mw_wrreg_next = WrReg_in;
          mw_pc_next    = PC_2ff;
          mw_err_next   = 1'b1;
        end else begin
          stall_comb = 1'b1;
          cnt_next   = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  assign Stall      = stall_comb;
  assign mem_req    = req_reg;
  assign mem_wr     = wr_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign valid_3ff  = mw_valid_reg;
  assign WbData_3ff = mw_data_reg;
  assign WrReg_3ff  = mw_wrreg_reg;
  assign RegWrt_3ff = mw_regwrt_reg;
  assign PC_3ff     = mw_pc_reg;
  assign Halt_3ff   = mw_halt_reg;
  assign Err_3ff    = mw_err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT_CYC=4).
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] ALU_Out;
  logic [15:0] WrData;
  logic        MemWrt_2ff;
  logic        MemRead_2ff;
  logic        RegWrt_in;
  logic [2:0]  WrReg_in;
  logic [15:0] PC_2ff;
  logic        Halt_in;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        Stall;
  logic        valid_3ff;
  logic [15:0] WbData_3ff;
  logic [2:0]  WrReg_3ff;
  logic        RegWrt_3ff;
  logic [15:0] PC_3ff;
  logic        Halt_3ff;
  logic        Err_3ff;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ALU_Out    (ALU_Out),
    .WrData     (WrData),
    .MemWrt_2ff (MemWrt_2ff),
    .MemRead_2ff(MemRead_2ff),
    .RegWrt_in  (RegWrt_in),
    .WrReg_in   (WrReg_in),
    .PC_2ff     (PC_2ff),
    .Halt_in    (Halt_in),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .Stall      (Stall),
    .valid_3ff  (valid_3ff),
    .WbData_3ff (WbData_3ff),
    .WrReg_3ff  (WrReg_3ff),
    .RegWrt_3ff (RegWrt_3ff),
    .PC_3ff     (PC_3ff),
    .Halt_3ff   (Halt_3ff),
    .Err_3ff    (Err_3ff)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    valid_in = 0; ALU_Out = '0; WrData = '0; MemWrt_2ff = 0; MemRead_2ff = 0;
    RegWrt_in = 0; WrReg_in = '0; PC_2ff = '0; Halt_in = 0;
  endtask

  task automatic present(input logic v, input logic rd, input logic wr,
                         input logic [15:0] alu, input logic [15:0] wd,
                         input logic rw, input logic [2:0] wreg,
                         input logic [15:0] pc, input logic h);
    valid_in = v; MemRead_2ff = rd; MemWrt_2ff = wr; ALU_Out = alu; WrData = wd;
    RegWrt_in = rw; WrReg_in = wreg; PC_2ff = pc; Halt_in = h;
  endtask

  // Holds the presented instruction until Stall is low, acking on BUSY cycle ack_at (0 = never).
  // Called at posedge+1; returns at posedge+1 just after the completion edge.
  task automatic run_access(input int ack_at, input logic [15:0] rdata,
                            output int stall_n, output int req_n, output int cycles,
                            output logic [15:0] req_addr, output logic req_wr,
                            output logic [15:0] req_wdata, output int unstable,
                            output bit completed);
    int busy_n;
    bit finish_now;
    busy_n = 0; stall_n = 0; req_n = 0; cycles = 0; unstable = 0; completed = 0;
    req_addr = '0; req_wr = 0; req_wdata = '0;
    for (int i = 0; i < 40 && !completed; i++) begin
      if (mem_req === 1'b1) begin
        busy_n++;
        if (busy_n == ack_at) begin
          mem_ack = 1; mem_rdata = rdata;
        end
      end
      @(negedge clk);
      cycles++;
      if (Stall === 1'b1) stall_n++;
      if (mem_req === 1'b1) begin
        if (req_n > 0 && (mem_addr !== req_addr || mem_wr !== req_wr || mem_wdata !== req_wdata))
          unstable++;
        req_n++;
        req_addr = mem_addr; req_wr = mem_wr; req_wdata = mem_wdata;
      end
      finish_now = (Stall === 1'b0);
      @(posedge clk); #1;
      mem_ack = 0; mem_rdata = '0;
      if (finish_now) completed = 1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({mem_req, mem_wr, mem_addr, mem_wdata} !== 34'd0) begin
      errors++; $display("FAIL reset_mem_if got %0b/%0b/%h/%h required 0", mem_req, mem_wr, mem_addr, mem_wdata);
    end
    checks++;
    if ({valid_3ff, WbData_3ff, WrReg_3ff, RegWrt_3ff, PC_3ff, Halt_3ff, Err_3ff} !== 39'd0) begin
      errors++; $display("FAIL reset_mw got v=%0b d=%h r=%0d w=%0b pc=%h h=%0b e=%0b required all 0",
                         valid_3ff, WbData_3ff, WrReg_3ff, RegWrt_3ff, PC_3ff, Halt_3ff, Err_3ff);
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    present(1, 1, 0, 16'h0040, 16'h0, 1, 3'd1, 16'h0200, 0);
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL reset_busy_req got %0b required 1", mem_req);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || valid_3ff !== 1'b0 || RegWrt_3ff !== 1'b0) begin
      errors++; $display("FAIL reset_async_drop got req=%0b v=%0b w=%0b required 0", mem_req, valid_3ff, RegWrt_3ff);
    end
    @(negedge clk); rst = 1; #1;
    checks++;
    if (mem_req !== 1'b0 || Stall !== 1'b1) begin
      errors++; $display("FAIL reset_idle got req=%0b stall=%0b required req=0 stall=1", mem_req, Stall);
    end
    idle_inputs();
    @(posedge clk); #1;
    $display("reset: async reset mid-access done");
  endtask

  task automatic test_bubble();
    present(0, 1, 0, 16'h0010, 16'h0, 1, 3'd2, 16'h0300, 0);
    mem_ack = 1;
    @(negedge clk);
    checks++;
    if (Stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL bubble_stall got stall=%0b req=%0b required 0", Stall, mem_req);
    end
    @(posedge clk); #1;
    mem_ack = 0; idle_inputs();
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1'b0 || RegWrt_3ff !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL bubble_mw got v=%0b w=%0b req=%0b required 0", valid_3ff, RegWrt_3ff, mem_req);
    end
    @(posedge clk); #1;
    $display("bubble: valid_in=0 with stray ack");
  endtask

  task automatic test_load();
    int sn, rn, cy, un; logic [15:0] a, wd; logic w; bit ok;
    present(1, 1, 0, 16'h0010, 16'h0, 1, 3'd3, 16'h0100, 0);
    run_access(4, 16'hBEEF, sn, rn, cy, a, w, wd, un, ok);
    idle_inputs();
    checks++;
    if (!ok) begin errors++; $display("FAIL load_timeout access never completed"); end
    checks++;
    if (sn != 4 || rn != 4 || un != 0) begin
      errors++; $display("FAIL load_stall got stall=%0d req=%0d unstable=%0d required 4/4/0", sn, rn, un);
    end
    checks++;
    if (a !== 16'h0010 || w !== 1'b0) begin
      errors++; $display("FAIL load_req got addr=%h wr=%0b required 0010/0", a, w);
    end
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1 || WbData_3ff !== 16'hBEEF || RegWrt_3ff !== 1 || WrReg_3ff !== 3'd3 ||
        PC_3ff !== 16'h0100 || Err_3ff !== 0 || mem_req !== 0) begin
      errors++; $display("FAIL load_mw got v=%0b d=%h w=%0b r=%0d pc=%h e=%0b req=%0b required 1/BEEF/1/3/0100/0/0",
                         valid_3ff, WbData_3ff, RegWrt_3ff, WrReg_3ff, PC_3ff, Err_3ff, mem_req);
    end
    @(posedge clk); #1;
    $display("load: addr 0010 rdata BEEF ack on busy cycle 4");
  endtask

  task automatic test_store();
    int sn, rn, cy, un; logic [15:0] a, wd; logic w; bit ok;
    present(1, 0, 1, 16'h0022, 16'h1234, 0, 3'd4, 16'h0104, 0);
    run_access(1, 16'h0000, sn, rn, cy, a, w, wd, un, ok);
    idle_inputs();
    // One stalled cycle plus the completion cycle: the store holds the X/M slot for 2 cycles.
    checks++;
    if (!ok || sn != 1 || cy != 2 || rn != 1) begin
      errors++; $display("FAIL store_timing got ok=%0b stall=%0d cycles=%0d req=%0d required 1/1/2/1", ok, sn, cy, rn);
    end
    checks++;
    if (a !== 16'h0022 || w !== 1'b1 || wd !== 16'h1234) begin
      errors++; $display("FAIL store_req got addr=%h wr=%0b wdata=%h required 0022/1/1234", a, w, wd);
    end
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1 || RegWrt_3ff !== 0 || WbData_3ff !== 16'h0022 || Err_3ff !== 0) begin
      errors++; $display("FAIL store_mw got v=%0b w=%0b d=%h e=%0b required 1/0/0022/0", valid_3ff, RegWrt_3ff, WbData_3ff, Err_3ff);
    end
    @(posedge clk); #1;
    $display("store: addr 0022 data 1234 ack on busy cycle 1");
  endtask

  task automatic test_misaligned();
    int sn, rn, cy, un; logic [15:0] a, wd; logic w; bit ok;
    present(1, 1, 0, 16'h0013, 16'h0, 1, 3'd5, 16'h0108, 0);
    run_access(0, 16'h0000, sn, rn, cy, a, w, wd, un, ok);
    idle_inputs();
    checks++;
    if (!ok || sn != 0 || rn != 0 || cy != 1) begin
      errors++; $display("FAIL misaligned_timing got ok=%0b stall=%0d req=%0d cycles=%0d required 1/0/0/1", ok, sn, rn, cy);
    end
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1 || Err_3ff !== 1 || RegWrt_3ff !== 0 || PC_3ff !== 16'h0108) begin
      errors++; $display("FAIL misaligned_mw got v=%0b e=%0b w=%0b pc=%h required 1/1/0/0108", valid_3ff, Err_3ff, RegWrt_3ff, PC_3ff);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (Err_3ff !== 0 || valid_3ff !== 0) begin
      errors++; $display("FAIL err_not_sticky got e=%0b v=%0b required 0/0", Err_3ff, valid_3ff);
    end
    @(posedge clk); #1;
    $display("misaligned: load 0013 flagged");
  endtask

  task automatic test_timeout();
    int sn, rn, cy, un; logic [15:0] a, wd; logic w; bit ok;
    present(1, 1, 0, 16'h0030, 16'h0, 1, 3'd6, 16'h010C, 0);
    run_access(0, 16'h0000, sn, rn, cy, a, w, wd, un, ok);
    idle_inputs();
    checks++;
    if (!ok || rn != 4 || sn != 4) begin
      errors++; $display("FAIL timeout_len got ok=%0b req=%0d stall=%0d required 1/4/4", ok, rn, sn);
    end
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1 || Err_3ff !== 1 || RegWrt_3ff !== 0 || mem_req !== 0 || Stall !== 0) begin
      errors++; $display("FAIL timeout_mw got v=%0b e=%0b w=%0b req=%0b stall=%0b required 1/1/0/0/0",
                         valid_3ff, Err_3ff, RegWrt_3ff, mem_req, Stall);
    end
    @(posedge clk); #1;
    $display("timeout: no ack, aborted after 4 busy cycles");
  endtask

  task automatic test_timeout_ack();
    int sn, rn, cy, un; logic [15:0] a, wd; logic w; bit ok;
    present(1, 1, 0, 16'h0032, 16'h0, 1, 3'd7, 16'h0110, 0);
    run_access(4, 16'h5A5A, sn, rn, cy, a, w, wd, un, ok);
    idle_inputs();
    checks++;
    if (!ok || rn != 4) begin
      errors++; $display("FAIL late_ack_len got ok=%0b req=%0d required 1/4", ok, rn);
    end
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1 || Err_3ff !== 0 || RegWrt_3ff !== 1 || WbData_3ff !== 16'h5A5A) begin
      errors++; $display("FAIL late_ack_mw got v=%0b e=%0b w=%0b d=%h required 1/0/1/5A5A", valid_3ff, Err_3ff, RegWrt_3ff, WbData_3ff);
    end
    @(posedge clk); #1;
    $display("timeout_ack: ack on final busy cycle wins");
  endtask

  task automatic test_back_to_back();
    int sn, rn, cy, un; logic [15:0] a, wd; logic w; bit ok;
    present(1, 1, 0, 16'h0050, 16'h0, 1, 3'd1, 16'h0120, 0);
    run_access(1, 16'hA5A5, sn, rn, cy, a, w, wd, un, ok);
    checks++;
    if (!ok || cy != 2) begin
      errors++; $display("FAIL b2b_latency got ok=%0b cycles=%0d required 1/2", ok, cy);
    end
    present(1, 0, 0, 16'h0044, 16'h0, 1, 3'd2, 16'h0122, 0);
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1 || WbData_3ff !== 16'hA5A5 || Stall !== 0 || PC_3ff !== 16'h0120) begin
      errors++; $display("FAIL b2b_load got v=%0b d=%h stall=%0b pc=%h required 1/A5A5/0/0120", valid_3ff, WbData_3ff, Stall, PC_3ff);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1 || WbData_3ff !== 16'h0044 || WrReg_3ff !== 3'd2) begin
      errors++; $display("FAIL b2b_alu got v=%0b d=%h r=%0d required 1/0044/2", valid_3ff, WbData_3ff, WrReg_3ff);
    end
    @(posedge clk); #1;
    $display("back_to_back: load then ALU op");
  endtask

  task automatic test_halt();
    int sn, rn, cy, un; logic [15:0] a, wd; logic w; bit ok;
    present(1, 0, 0, 16'h00FF, 16'h0, 1, 3'd5, 16'h0200, 0);
    @(posedge clk); #1;
    present(1, 0, 0, 16'h0000, 16'h0, 0, 3'd0, 16'h0202, 1);
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1 || WbData_3ff !== 16'h00FF || RegWrt_3ff !== 1 || Halt_3ff !== 0) begin
      errors++; $display("FAIL halt_add got v=%0b d=%h w=%0b h=%0b required 1/00FF/1/0", valid_3ff, WbData_3ff, RegWrt_3ff, Halt_3ff);
    end
    @(posedge clk); #1;
    present(1, 1, 0, 16'h0060, 16'h0, 1, 3'd3, 16'h0204, 0);
    @(negedge clk);
    checks++;
    if (valid_3ff !== 1 || Halt_3ff !== 1 || PC_3ff !== 16'h0202) begin
      errors++; $display("FAIL halt_pass got v=%0b h=%0b pc=%h required 1/1/0202", valid_3ff, Halt_3ff, PC_3ff);
    end
    @(posedge clk); #1;
    run_access(0, 16'h0000, sn, rn, cy, a, w, wd, un, ok);
    idle_inputs();
    checks++;
    if (!ok || rn != 0 || sn != 0) begin
      errors++; $display("FAIL halted_load got ok=%0b req=%0d stall=%0d required 1/0/0", ok, rn, sn);
    end
    @(negedge clk);
    checks++;
    if (valid_3ff !== 0 || Halt_3ff !== 0 || RegWrt_3ff !== 0) begin
      errors++; $display("FAIL halted_bubble got v=%0b h=%0b w=%0b required 0/0/0", valid_3ff, Halt_3ff, RegWrt_3ff);
    end
    @(posedge clk); #1;
    $display("halt: ADD, HALT, then ignored load");
  endtask

  initial begin
    rst = 0;
    mem_ack = 0;
    mem_rdata = '0;
    idle_inputs();
    test_reset();
    test_bubble();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_timeout_ack();
    test_back_to_back();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
